// File: rtl/midi_preset_bank_ctrl.sv
// midi_preset_bank_ctrl
// This controller holds a table of MIDI presets, organised as buttons x banks, in on-chip RAM.
// After reset the table is mirrored in from SPI flash, with a bounded number of retries per word.
// In save mode the controller learns presets from midi_in. When the table is dirty it writes
// the whole table back to flash. A button press fires the stored command towards midi_out.
module midi_preset_bank_ctrl #(
  parameter int          BUTTONS_CNT = 4,
  parameter int          BANKS       = 4,
  parameter logic [23:0] MEMADDR     = 24'h1ffd80,
  parameter int          RETRY_MAX   = 3,
  parameter int          BI_W        = $clog2(BUTTONS_CNT + 1),
  parameter int          BK_W        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BI_W-1:0] btn_index,
  input  logic            save_mode,
  input  logic            bank_up,
  input  logic            bank_down,
  input  logic [7:0]      status_in,
  input  logic [7:0]      data1_in,
  input  logic [7:0]      data2_in,
  input  logic [1:0]      bytes_cnt_in,
  output logic [23:0]     spi_adr_o,
  output logic [31:0]     spi_dat_o,
  output logic            spi_we_o,
  output logic            spi_stb_o,
  output logic            spi_tga_o,
  input  logic [31:0]     spi_dat_i,
  input  logic            spi_ack_i,
  input  logic            spi_rty_i,
  output logic [7:0]      status,
  output logic [7:0]      data1,
  output logic [7:0]      data2,
  output logic [7:0]      cmd_bits_cnt,
  output logic            cmd_trigger_out,
  output logic [BK_W-1:0] bank_sel,
  output logic            busy,
  output logic            fail
);

  localparam int ENTRIES = BANKS * BUTTONS_CNT;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int RC_W    = $clog2(RETRY_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
  localparam logic [BK_W-1:0]  LAST_BANK = BK_W'(BANKS - 1);

  typedef enum logic [2:0] {
    LOAD_REQ, LOAD_WAIT, IDLE, WB_REQ, WB_WAIT, ACK_REL, FAIL
  } state_t;

  // Preset table: one word per entry; an erased flash word marks the entry as empty.
  logic [31:0]      table_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_reg;

  state_t           state_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic [RC_W-1:0]  retry_cnt_reg;
  logic             loading_reg;   // the current pass is the initial load (not a write-back)
  logic             dirty_reg;
  logic [BI_W-1:0]  btn_prev_reg;

  logic             btn_ok;
  logic [IDX_W-1:0] btn_entry;
  logic             learn_en;
  logic             ack_wr;
  logic             trig_fire;
  logic [7:0]       learn_bits;
  logic [31:0]      trig_word;
  logic [31:0]      wb_word;
  logic [23:0]      word_addr;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata;
  logic             ram_wvalid;

  assign btn_ok     = (btn_index != '0) && (32'(btn_index) <= 32'(BUTTONS_CNT));
  assign btn_entry  = IDX_W'(32'(bank_sel) * 32'(BUTTONS_CNT) + 32'(btn_index) - 32'd1);
  assign learn_en   = btn_ok && save_mode && !loading_reg;
  assign ack_wr     = (state_reg == LOAD_WAIT) && spi_ack_i;
  assign learn_bits = {6'd0, bytes_cnt_in} * 8'd10;
  assign trig_word  = table_mem[btn_entry];
  assign trig_fire  = btn_ok && (btn_prev_reg == '0) && !save_mode && valid_reg[btn_entry];
  assign wb_word    = valid_reg[word_idx_reg] ? table_mem[word_idx_reg] : 32'hFFFF_FFFF;
  assign word_addr  = MEMADDR + 24'({word_idx_reg, 2'b00});

  // Single table write port: flash load data has priority, learning is locked out while loading
  always_comb begin
    ram_we     = 1'b0;
    ram_waddr  = word_idx_reg;
    ram_wdata  = spi_dat_i;
    ram_wvalid = (spi_dat_i != 32'hFFFF_FFFF);
    if (ack_wr) begin
      ram_we = 1'b1;
    end else if (learn_en) begin
      ram_we     = 1'b1;
      ram_waddr  = btn_entry;
      ram_wdata  = {status_in, data1_in, data2_in, learn_bits};
      ram_wvalid = 1'b1;
    end
  end

  // Preset RAM storage (no reset; validity is tracked separately)
  always_ff @(posedge clk) begin
    if (ram_we) begin
      table_mem[ram_waddr] <= ram_wdata;
    end
  end

  // Per-entry valid flags, cleared by reset so a failed load leaves entries empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (ram_we) begin
      valid_reg[ram_waddr] <= ram_wvalid;
    end
  end

  // Flash transfer FSM: load, write-back, ack release handshake, bounded retry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= LOAD_REQ;
      word_idx_reg  <= '0;
      retry_cnt_reg <= '0;
      loading_reg   <= 1'b1;
      dirty_reg     <= 1'b0;
      spi_adr_o     <= '0;
      spi_dat_o     <= '0;
      spi_we_o      <= 1'b0;
      spi_stb_o     <= 1'b0;
      spi_tga_o     <= 1'b0;
      busy          <= 1'b0;
      fail          <= 1'b0;
    end else begin
      if (learn_en) begin
        dirty_reg <= 1'b1;
      end
      case (state_reg)
        LOAD_REQ: begin
          spi_stb_o <= 1'b1;
          spi_we_o  <= 1'b0;
          spi_tga_o <= 1'b0;
          spi_adr_o <= word_addr;
          busy      <= 1'b1;
          state_reg <= LOAD_WAIT;
        end
        LOAD_WAIT, WB_WAIT: begin
          if (spi_ack_i) begin
            spi_stb_o     <= 1'b0;
            spi_we_o      <= 1'b0;
            spi_tga_o     <= 1'b0;
            retry_cnt_reg <= '0;
            state_reg     <= ACK_REL;
          end else if (spi_rty_i) begin
            spi_stb_o     <= 1'b0;
            spi_we_o      <= 1'b0;
            spi_tga_o     <= 1'b0;
            retry_cnt_reg <= retry_cnt_reg + 1'b1;
            if ((32'(retry_cnt_reg) + 32'd1) < 32'(RETRY_MAX)) begin
              // one cycle with strobe low, then the same word again
              state_reg <= (state_reg == LOAD_WAIT) ? LOAD_REQ : WB_REQ;
            end else begin
              fail        <= 1'b1;
              busy        <= 1'b0;
              loading_reg <= 1'b0;
              state_reg   <= FAIL;
            end
          end
        end
        ACK_REL: begin
          // never start the next access while the slave still holds ack
          if (!spi_ack_i) begin
            if (word_idx_reg == LAST_IDX) begin
              word_idx_reg <= '0;
              loading_reg  <= 1'b0;
              busy         <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              word_idx_reg <= word_idx_reg + 1'b1;
              state_reg    <= loading_reg ? LOAD_REQ : WB_REQ;
            end
          end
        end
        IDLE: begin
          if (dirty_reg && !save_mode) begin
            dirty_reg    <= 1'b0;
            word_idx_reg <= '0;
            busy         <= 1'b1;
            state_reg    <= WB_REQ;
          end
        end
        WB_REQ: begin
          // word 0 carries the erase-sector tag; the whole table sits in that sector
          spi_stb_o <= 1'b1;
          spi_we_o  <= 1'b1;
          spi_tga_o <= (word_idx_reg == '0);
          spi_adr_o <= word_addr;
          spi_dat_o <= wb_word;
          busy      <= 1'b1;
          state_reg <= WB_WAIT;
        end
        FAIL: begin
          spi_stb_o <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= LOAD_REQ;
        end
      endcase
    end
  end

  // Button edge detection and one-cycle command pulse towards midi_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_reg    <= '0;
      status          <= '0;
      data1           <= '0;
      data2           <= '0;
      cmd_bits_cnt    <= '0;
      cmd_trigger_out <= 1'b0;
    end else begin
      btn_prev_reg    <= btn_index;
      cmd_trigger_out <= 1'b0;
      if (trig_fire) begin
        status          <= trig_word[31:24];
        data1           <= trig_word[23:16];
        data2           <= trig_word[15:8];
        cmd_bits_cnt    <= trig_word[7:0];
        cmd_trigger_out <= 1'b1;
      end
    end
  end

  // Bank selection with wrap-around; simultaneous up and down cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel <= '0;
    end else if (bank_up && !bank_down) begin
      bank_sel <= (bank_sel == LAST_BANK) ? '0 : bank_sel + 1'b1;
    end else if (bank_down && !bank_up) begin
      bank_sel <= (bank_sel == '0) ? LAST_BANK : bank_sel - 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_preset_bank_ctrl.sv
// Testbench for midi_preset_bank_ctrl: behavioural flash slave, table vectors, random presses
`timescale 1ns/1ps
module tb_midi_preset_bank_ctrl;
  localparam int          BUTTONS_CNT = 4;
  localparam int          BANKS       = 4;
  localparam int          ENTRIES     = BANKS * BUTTONS_CNT;
  localparam int          RETRY_MAX   = 3;
  localparam logic [23:0] MEMADDR     = 24'h1ffd80;
  localparam int          BI_W        = 3;
  localparam int          BK_W        = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [BI_W-1:0] btn_index = '0;
  logic save_mode = 1'b0, bank_up = 1'b0, bank_down = 1'b0;
  logic [7:0] status_in = '0, data1_in = '0, data2_in = '0;
  logic [1:0] bytes_cnt_in = '0;
  logic [23:0] spi_adr_o;
  logic [31:0] spi_dat_o;
  logic spi_we_o, spi_stb_o, spi_tga_o;
  logic [31:0] spi_dat_i = '0;
  logic spi_ack_i = 1'b0, spi_rty_i = 1'b0;
  logic [7:0] status, data1, data2, cmd_bits_cnt;
  logic cmd_trigger_out;
  logic [BK_W-1:0] bank_sel;
  logic busy, fail;

  midi_preset_bank_ctrl #(
    .BUTTONS_CNT(BUTTONS_CNT), .BANKS(BANKS), .MEMADDR(MEMADDR),
    .RETRY_MAX(RETRY_MAX), .BI_W(BI_W), .BK_W(BK_W)
  ) dut (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .bank_up(bank_up), .bank_down(bank_down), .status_in(status_in),
    .data1_in(data1_in), .data2_in(data2_in), .bytes_cnt_in(bytes_cnt_in),
    .spi_adr_o(spi_adr_o), .spi_dat_o(spi_dat_o), .spi_we_o(spi_we_o),
    .spi_stb_o(spi_stb_o), .spi_tga_o(spi_tga_o), .spi_dat_i(spi_dat_i),
    .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i), .status(status),
    .data1(data1), .data2(data2), .cmd_bits_cnt(cmd_bits_cnt),
    .cmd_trigger_out(cmd_trigger_out), .bank_sel(bank_sel), .busy(busy), .fail(fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural flash slave ----------------
  typedef struct {
    logic [23:0] adr;
    logic        we;
    logic        tga;
    logic [31:0] dat;
  } txn_t;

  logic [31:0] fl [ENTRIES];
  int   rty_left [ENTRIES];
  bit   rty_always = 1'b0;
  int   ack_hold   = 1;
  bit   stall      = 1'b0;
  int   stall_word = 0;
  bit   stall_seen = 1'b0;
  int   ack_cnt    = 0;
  int   slv_w;
  txn_t slv_t;
  txn_t log_q[$];

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        spi_ack_i = 1'b0;
        spi_rty_i = 1'b0;
        ack_cnt   = 0;
      end else if (ack_cnt > 0) begin
        check("stb_low_while_ack", spi_stb_o, 32'd0);
        ack_cnt--;
        if (ack_cnt == 0) spi_ack_i = 1'b0;
      end else if (spi_rty_i) begin
        spi_rty_i = 1'b0;
      end else if (spi_stb_o) begin
        slv_w = int'((spi_adr_o - MEMADDR) >> 2) % ENTRIES;
        if (stall && slv_w == stall_word) begin
          stall_seen = 1'b1;
        end else begin
          slv_t.adr = spi_adr_o;
          slv_t.we  = spi_we_o;
          slv_t.tga = spi_tga_o;
          slv_t.dat = spi_dat_o;
          log_q.push_back(slv_t);
          if (rty_always || rty_left[slv_w] > 0) begin
            if (rty_left[slv_w] > 0) rty_left[slv_w]--;
            spi_rty_i = 1'b1;
            $display("flash adr %h we %0d: retry", spi_adr_o, spi_we_o);
          end else begin
            if (spi_we_o) begin
              if (spi_tga_o) begin
                for (int k = 0; k < ENTRIES; k++) fl[k] = 32'hFFFF_FFFF;
              end
              fl[slv_w] = spi_dat_o;
            end else begin
              spi_dat_i = fl[slv_w];
            end
            spi_ack_i = 1'b1;
            ack_cnt   = ack_hold;
            $display("flash adr %h we %0d tga %0d data %h: ack", spi_adr_o, spi_we_o, spi_tga_o,
                     spi_we_o ? spi_dat_o : fl[slv_w]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0]        ref_tab [ENTRIES];
  logic [ENTRIES-1:0] ref_valid;
  int bank_m, prev_m;

  typedef struct {
    logic        up;
    logic        down;
    logic [2:0]  btn;
    logic [1:0]  exp_bank;
    logic        exp_trig;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs [11];

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check({name, "_done"}, busy, 32'd0);
  endtask

  int   n, b, idx, pulses, stb_seen;
  bit   u, d, exp_t;
  int   exp_w [$];
  logic [31:0] exp_dat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // table vectors: bank 0 after reset, flash word e = {B0, 46+e, 7F, 30}, entry 3 empty
    vecs[0]  = '{1'b0, 1'b0, 3'd2, 2'd0, 1'b1, 32'hB02F7F1E};
    vecs[1]  = '{1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 32'hB02E7F1E};
    vecs[3]  = '{1'b1, 1'b0, 3'd3, 2'd1, 1'b1, 32'hB0307F1E};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd0, 2'd3, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 3'd4, 2'd3, 1'b1, 32'hB03D7F1E};
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 2'd3, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 32'hB0327F1E};

    for (int e = 0; e < ENTRIES; e++) begin
      fl[e]       = {8'hB0, 8'(46 + e), 8'h7F, 8'd30};
      rty_left[e] = 0;
    end
    fl[3]       = 32'hFFFF_FFFF;
    rty_left[5] = 2;
    ack_hold    = 5;
    for (int e = 0; e < ENTRIES; e++) begin
      ref_tab[e]   = fl[e];
      ref_valid[e] = (fl[e] != 32'hFFFF_FFFF);
    end

    // reset state
    tick(); tick();
    check("rst_stb", spi_stb_o, 32'd0);
    check("rst_we", spi_we_o, 32'd0);
    check("rst_tga", spi_tga_o, 32'd0);
    check("rst_adr", spi_adr_o, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_fail", fail, 32'd0);
    check("rst_trig", cmd_trigger_out, 32'd0);
    check("rst_bank", bank_sel, 32'd0);
    check("rst_cmd", {status, data1, data2, cmd_bits_cnt}, 32'd0);
    rst = 1'b0;

    // initial load with retries on word 5 and ack held for 5 cycles
    wait_done("load", 3000);
    check("load_fail_flag", fail, 32'd0);
    for (int e = 0; e < ENTRIES; e++) begin
      exp_w.push_back(e);
      if (e == 5) begin exp_w.push_back(5); exp_w.push_back(5); end
    end
    check("load_txn_count", log_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      check($sformatf("load_adr%0d", i), log_q[i].adr, MEMADDR + 24'(4 * exp_w[i]));
      check($sformatf("load_we%0d", i), {log_q[i].we, log_q[i].tga}, 32'd0);
    end

    // table-driven button/bank vectors
    for (int i = 0; i < 11; i++) begin
      bank_up = vecs[i].up; bank_down = vecs[i].down; btn_index = vecs[i].btn;
      tick();
      check($sformatf("vec%0d_bank", i), bank_sel, vecs[i].exp_bank);
      check($sformatf("vec%0d_trig", i), cmd_trigger_out, vecs[i].exp_trig);
      if (vecs[i].exp_trig)
        check($sformatf("vec%0d_word", i), {status, data1, data2, cmd_bits_cnt}, vecs[i].exp_word);
      bank_up = 1'b0; bank_down = 1'b0; btn_index = '0;
      tick();
      check($sformatf("vec%0d_pulse_end", i), cmd_trigger_out, 32'd0);
      $display("vector %0d: btn %0d up %0d down %0d -> bank %0d trig %0d", i, vecs[i].btn,
               vecs[i].up, vecs[i].down, bank_sel, vecs[i].exp_trig);
    end

    // held button: exactly one pulse (bank 1, btn 2 -> entry 5, loaded after retries)
    pulses = 0;
    btn_index = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmd_trigger_out) begin
        pulses++;
        check("hold_word", {status, data1, data2, cmd_bits_cnt}, 32'hB0337F1E);
      end
    end
    check("hold_pulses", pulses, 32'd1);
    btn_index = '0;
    tick();

    // randomized presses and bank moves against the model
    bank_m = 1;
    prev_m = 0;
    for (int i = 0; i < 300; i++) begin
      u = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 2) == 0) ? prev_m : int'($urandom_range(0, BUTTONS_CNT));
      idx = bank_m * BUTTONS_CNT + b - 1;
      exp_t = (prev_m == 0) && (b != 0) && ref_valid[idx];
      bank_up = u; bank_down = d; btn_index = BI_W'(b);
      tick();
      check("rnd_trig", cmd_trigger_out, exp_t);
      if (exp_t) begin
        check("rnd_word", {status, data1, data2, cmd_bits_cnt}, ref_tab[idx]);
        $display("random press bank %0d btn %0d -> %h", bank_m, b, ref_tab[idx]);
      end
      if (u && !d) bank_m = (bank_m + 1) % BANKS;
      else if (d && !u) bank_m = (bank_m + BANKS - 1) % BANKS;
      check("rnd_bank", bank_sel, bank_m);
      prev_m = b;
    end
    bank_up = 1'b0; bank_down = 1'b0; btn_index = '0;
    tick();

    // learn C0/42/00 with 2 bytes on button 1, then write back the whole table
    ack_hold = 1;
    save_mode = 1'b1; btn_index = 3'd1;
    status_in = 8'hC0; data1_in = 8'h42; data2_in = 8'h00; bytes_cnt_in = 2'd2;
    tick();
    btn_index = '0;
    tick();
    ref_tab[bank_m * BUTTONS_CNT] = 32'hC042_0014;
    ref_valid[bank_m * BUTTONS_CNT] = 1'b1;
    log_q.delete();
    save_mode = 1'b0;
    wait_done("wb", 2000);
    check("wb_txn_count", log_q.size(), ENTRIES);
    for (int i = 0; i < ENTRIES && i < log_q.size(); i++) begin
      exp_dat = ref_valid[i] ? ref_tab[i] : 32'hFFFF_FFFF;
      check($sformatf("wb_adr%0d", i), log_q[i].adr, MEMADDR + 24'(4 * i));
      check($sformatf("wb_we_tga%0d", i), {log_q[i].we, log_q[i].tga}, {1'b1, (i == 0)});
      check($sformatf("wb_dat%0d", i), log_q[i].dat, exp_dat);
    end
    btn_index = 3'd1;
    tick();
    check("learned_trig", cmd_trigger_out, 32'd1);
    check("learned_word", {status, data1, data2, cmd_bits_cnt}, 32'hC042_0014);
    btn_index = '0;
    tick();

    // reset while the load waits on word 6
    stall = 1'b1; stall_word = 6; stall_seen = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n = 0;
    while (!stall_seen && n < 500) begin tick(); n++; end
    check("stall_reached", stall_seen, 32'd1);
    check("stb_before_rst", spi_stb_o, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_stb", spi_stb_o, 32'd0);
    check("rst_async_busy", busy, 32'd0);
    stall = 1'b0;
    log_q.delete();
    tick();
    rst = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 50) begin tick(); n++; end
    check("restart_seen", (log_q.size() != 0), 32'd1);
    if (log_q.size() != 0) check("restart_adr", log_q[0].adr, MEMADDR);

    // retry on every attempt -> sticky fail, no further accesses
    rty_always = 1'b1;
    rst = 1'b1; tick(); tick();
    log_q.delete();
    rst = 1'b0;
    n = 0;
    while (!fail && n < 200) begin tick(); n++; end
    check("fail_flag", fail, 32'd1);
    check("fail_busy", busy, 32'd0);
    stb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spi_stb_o) stb_seen++;
    end
    check("fail_no_stb", stb_seen, 32'd0);
    check("fail_attempts", log_q.size(), RETRY_MAX);
    for (int i = 0; i < log_q.size(); i++)
      check($sformatf("fail_adr%0d", i), log_q[i].adr, MEMADDR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
